uart_tx_arbiter: RTL and testbench



---
 rtl/uart_arb_pkg.sv | 8 +
 rtl/uart_tx_arbiter_rr_picker.sv | 19 +
 rtl/uart_tx_arbiter.sv | 60 ++++++
 tb/tb_uart_tx_arbiter.sv | 119 +++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared types, constants and helpers for the UART transmit arbiter.
package uart_arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_e;
  localparam int UART_BYTE_W = 8;
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// rr_picker: combinational circular-priority encoder starting just after the last grant.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [IW-1:0] o_win,
  output logic          o_any
);
  // Walk from farthest to nearest so the nearest requester after i_last is assigned last and wins.
  always_comb begin
    o_win = '0;
    o_any = |i_req;
    for (int i = N; i >= 1; i--) begin
      if (i_req[(int'(i_last) + i) % N]) o_win = IW'((int'(i_last) + i) % N);
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one UART byte input among requesters, one grant per message.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16,
  localparam int IW = clog2_min1(NUM_REQ)
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  input  logic [NUM_REQ*UART_BYTE_W-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]             i_req_last,
  output logic [NUM_REQ-1:0]             o_req_ready,
  output logic [UART_BYTE_W-1:0]         o_data_in,
  output logic                           o_data_in_valid,
  input  logic                           i_data_in_ready,
  output logic [IW-1:0]                  o_grant_id,
  output logic                           o_busy
);
  arb_state_e state_q, state_d;
  logic [IW-1:0] grant_q, grant_d, last_q, last_d, win;
  logic [7:0] cnt_q, cnt_d;
  logic any, hs, rel;
  rr_picker #(.N(NUM_REQ), .IW(IW)) u_picker (
    .i_req  (i_req_valid),
    .i_last (last_q),
    .o_win  (win),
    .o_any  (any)
  );
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end
  // Release on the handshake of the message's last byte or of the MAX_BURST-th byte.
  always_comb begin
    hs      = o_data_in_valid & i_data_in_ready;
    rel     = hs & (i_req_last[grant_q] | (cnt_q + 8'd1 == 8'(MAX_BURST)));
    state_d = (state_q == ARB_IDLE) ? (any ? ARB_BURST : ARB_IDLE) : (rel ? ARB_IDLE : ARB_BURST);
    grant_d = (state_q == ARB_IDLE && any) ? win : grant_q;
    cnt_d   = (state_q == ARB_IDLE) ? '0 : hs ? cnt_q + 8'd1 : cnt_q;
    last_d  = rel ? grant_q : last_q;
  end
  always_comb begin
    o_busy          = state_q == ARB_BURST;
    o_grant_id      = grant_q;
    o_data_in       = o_busy ? i_req_data[int'(grant_q)*UART_BYTE_W +: UART_BYTE_W] : '0;
    o_data_in_valid = o_busy & i_req_valid[grant_q];
    o_req_ready     = o_busy ? (NUM_REQ'(i_data_in_ready) << grant_q) : '0;
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: table-driven directed check of the UART transmit arbiter with MAX_BURST=4.
module tb_uart_tx_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid, req_last, req_ready;
  logic [31:0] req_data;
  logic [7:0]  data_in;
  logic        data_in_valid, data_in_ready, busy;
  logic [1:0]  grant_id;
  int errors = 0;
  int checks = 0;
  typedef struct {
    logic [3:0]  v;
    logic [31:0] d;
    logic [3:0]  l;
    logic        r;
    logic [15:0] exp;
  } vec_t;
  vec_t vq[$];
  uart_tx_arbiter #(.NUM_REQ(4), .MAX_BURST(4)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_req_valid     (req_valid),
    .i_req_data      (req_data),
    .i_req_last      (req_last),
    .o_req_ready     (req_ready),
    .o_data_in       (data_in),
    .o_data_in_valid (data_in_valid),
    .i_data_in_ready (data_in_ready),
    .o_grant_id      (grant_id),
    .o_busy          (busy)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] e(input logic b, input logic [1:0] g, input logic va,
                                   input logic [7:0] dt, input logic [3:0] rr);
    return {b, g, va, dt, rr};
  endfunction
  function automatic logic [15:0] act();
    return {busy, grant_id, data_in_valid, data_in, req_ready};
  endfunction
  task automatic add(input logic [3:0] v, input logic [31:0] d, input logic [3:0] l,
                     input logic r, input logic [15:0] x);
    vec_t t;
    t.v = v; t.d = d; t.l = l; t.r = r; t.exp = x;
    vq.push_back(t);
  endtask
  task automatic chk(input string nm, input logic [15:0] a, input logic [15:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got {busy,gid,val,data,ready}=%h expected %h", nm, a, x);
    end
  endtask
  initial begin
    rst_n = 1'b0; req_valid = '0; req_data = '0; req_last = '0; data_in_ready = 1'b0;
    // single byte from req0
    add(4'b0000, 32'h0, 4'b0000, 1, e(0, 0, 0, 8'h00, 4'b0000));
    add(4'b0001, 32'h41, 4'b0001, 1, e(0, 0, 0, 8'h00, 4'b0000));
    add(4'b0001, 32'h41, 4'b0001, 1, e(1, 0, 1, 8'h41, 4'b0001));
    add(4'b0000, 32'h0, 4'b0000, 1, e(0, 0, 0, 8'h00, 4'b0000));
    // req1 and req2 three-byte messages
    add(4'b0110, 32'h00B1A100, 4'b0000, 1, e(0, 0, 0, 8'h00, 4'b0000));
    add(4'b0110, 32'h00B1A100, 4'b0000, 1, e(1, 1, 1, 8'hA1, 4'b0010));
    add(4'b0110, 32'h00B1A200, 4'b0000, 1, e(1, 1, 1, 8'hA2, 4'b0010));
    add(4'b0110, 32'h00B1A300, 4'b0010, 1, e(1, 1, 1, 8'hA3, 4'b0010));
    add(4'b0100, 32'h00B10000, 4'b0000, 1, e(0, 1, 0, 8'h00, 4'b0000));
    add(4'b0100, 32'h00B10000, 4'b0000, 1, e(1, 2, 1, 8'hB1, 4'b0100));
    add(4'b0100, 32'h00B20000, 4'b0000, 1, e(1, 2, 1, 8'hB2, 4'b0100));
    add(4'b0100, 32'h00B30000, 4'b0100, 1, e(1, 2, 1, 8'hB3, 4'b0100));
    add(4'b0000, 32'h0, 4'b0000, 1, e(0, 2, 0, 8'h00, 4'b0000));
    // req0 unbounded stream forced off after 4 bytes, req3 served, req0 resumes
    add(4'b0001, 32'h000000C0, 4'b0000, 1, e(0, 2, 0, 8'h00, 4'b0000));
    add(4'b1001, 32'hD10000C0, 4'b1000, 1, e(1, 0, 1, 8'hC0, 4'b0001));
    add(4'b1001, 32'hD10000C1, 4'b1000, 1, e(1, 0, 1, 8'hC1, 4'b0001));
    add(4'b1001, 32'hD10000C2, 4'b1000, 1, e(1, 0, 1, 8'hC2, 4'b0001));
    add(4'b1001, 32'hD10000C3, 4'b1000, 1, e(1, 0, 1, 8'hC3, 4'b0001));
    add(4'b1001, 32'hD10000C4, 4'b1000, 1, e(0, 0, 0, 8'h00, 4'b0000));
    add(4'b1001, 32'hD10000C4, 4'b1000, 1, e(1, 3, 1, 8'hD1, 4'b1000));
    add(4'b0001, 32'h000000C4, 4'b0000, 1, e(0, 3, 0, 8'h00, 4'b0000));
    add(4'b0001, 32'h000000C4, 4'b0000, 1, e(1, 0, 1, 8'hC4, 4'b0001));
    // UART stall for 5 cycles; the counter must hold so release lands on C7
    for (int i = 0; i < 5; i++) add(4'b0001, 32'h000000C5, 4'b0000, 0, e(1, 0, 1, 8'hC5, 4'b0000));
    add(4'b0001, 32'h000000C5, 4'b0000, 1, e(1, 0, 1, 8'hC5, 4'b0001));
    add(4'b0001, 32'h000000C6, 4'b0000, 1, e(1, 0, 1, 8'hC6, 4'b0001));
    add(4'b0001, 32'h000000C7, 4'b0000, 1, e(1, 0, 1, 8'hC7, 4'b0001));
    add(4'b0000, 32'h0, 4'b0000, 1, e(0, 0, 0, 8'h00, 4'b0000));
    // granted req2 drops valid while req1 waits
    add(4'b0100, 32'h00E10000, 4'b0000, 1, e(0, 0, 0, 8'h00, 4'b0000));
    add(4'b0100, 32'h00E10000, 4'b0000, 1, e(1, 2, 1, 8'hE1, 4'b0100));
    for (int i = 0; i < 3; i++) add(4'b0010, 32'h00E2F100, 4'b0000, 1, e(1, 2, 0, 8'hE2, 4'b0100));
    add(4'b0110, 32'h00E2F100, 4'b0100, 1, e(1, 2, 1, 8'hE2, 4'b0100));
    add(4'b0010, 32'h0000F100, 4'b0010, 1, e(0, 2, 0, 8'h00, 4'b0000));
    add(4'b0010, 32'h0000F100, 4'b0010, 1, e(1, 1, 1, 8'hF1, 4'b0010));
    add(4'b0000, 32'h0, 4'b0000, 1, e(0, 1, 0, 8'h00, 4'b0000));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      req_valid = vq[i].v; req_data = vq[i].d; req_last = vq[i].l; data_in_ready = vq[i].r;
      #2;
      chk($sformatf("vec%0d", i), act(), vq[i].exp);
    end
    // asynchronous reset mid-burst; last_grant returns to 3 so req0 beats req2 afterwards
    @(negedge clk);
    req_valid = 4'b0101; req_data = 32'h00620060; req_last = '0; data_in_ready = 1'b1;
    #2 chk("rst_pre_idle", act(), e(0, 1, 0, 8'h00, 4'b0000));
    @(posedge clk);
    #2 chk("rst_burst", act(), e(1, 2, 1, 8'h62, 4'b0100));
    rst_n = 1'b0;
    #1 chk("rst_async", act(), e(0, 0, 0, 8'h00, 4'b0000));
    @(negedge clk);
    rst_n = 1'b1;
    #2 chk("rst_idle", act(), e(0, 0, 0, 8'h00, 4'b0000));
    @(posedge clk);
    #2 chk("rst_rewin", act(), e(1, 0, 1, 8'h60, 4'b0001));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
